// File: rtl/dac_tx_streamer.sv
// Wishbone-fed 16-bit SPI DAC transmit path: TX FIFO, sample-rate timer, serializer, CSRs.
// Optional DAC_TX_REPEAT_LAST_EN: an underrun tick resends the last transmitted sample.
module dac_tx_streamer #(
  parameter int                   ADDRWIDTH     = 10,
  parameter int                   DATAWIDTH     = 32,
  parameter int                   FIFO_AW       = 4,
  parameter int                   CLK_DIV       = 4,
  parameter logic [DATAWIDTH-1:0] DEF_REG_VALUE = 32'hFAB_DEF_AC
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
  input  logic                 WBs_CYC_i,
  input  logic                 WBs_STB_i,
  input  logic                 WBs_WE_i,
  input  logic [3:0]           WBs_BYTE_STB_i,
  input  logic [DATAWIDTH-1:0] WBs_DAT_i,
  output logic [DATAWIDTH-1:0] WBs_DAT_o,
  output logic                 WBs_ACK_o,
  output logic                 DAC_SCLK_o,
  output logic                 DAC_SYNC_n_o,
  output logic                 DAC_SDO_o,
  output logic                 TX_Low_IRQ_o
);

  localparam int              DEPTH    = 2 ** FIFO_AW;
  localparam int              LW       = FIFO_AW + 1;
  localparam logic [15:0]     DIV_M1   = 16'(CLK_DIV - 1);
  localparam logic [LW-1:0]   FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_GAP} state_t;

  logic clk, rst;
  assign clk = WBs_CLK_i;
  assign rst = WBs_RST_i;

  logic unused_ok;
  assign unused_ok = ^{WBs_DAT_i[DATAWIDTH-1:16], WBs_BYTE_STB_i[3:2]};

  // Bus handshake and decode
  logic ack_q, ack_d, bus_req, bus_wr;
  logic sel_ctrl, sel_rate, sel_data, sel_stat, sel_thr;

  assign bus_req  = WBs_CYC_i & WBs_STB_i & ~ack_q;
  assign bus_wr   = bus_req & WBs_WE_i;
  assign ack_d    = bus_req;
  assign sel_ctrl = (WBs_ADR_i == ADDRWIDTH'(0));
  assign sel_rate = (WBs_ADR_i == ADDRWIDTH'(1));
  assign sel_data = (WBs_ADR_i == ADDRWIDTH'(2));
  assign sel_stat = (WBs_ADR_i == ADDRWIDTH'(3));
  assign sel_thr  = (WBs_ADR_i == ADDRWIDTH'(4));

  logic            enable_q, enable_d, irq_en_q, irq_en_d;
  logic [15:0]     rate_q, rate_d;
  logic [LW-1:0]   thresh_q, thresh_d;
  logic            underrun_q, underrun_d, overflow_q, overflow_d;
  logic            underrun_clr, overflow_clr, underrun_set;
  logic            flush, push_req, pop_req;

  always_comb begin
    enable_d     = enable_q;
    irq_en_d     = irq_en_q;
    rate_d       = rate_q;
    thresh_d     = thresh_q;
    flush        = 1'b0;
    push_req     = 1'b0;
    underrun_clr = 1'b0;
    overflow_clr = 1'b0;
    if (bus_wr) begin
      if (sel_ctrl && WBs_BYTE_STB_i[0]) begin
        enable_d = WBs_DAT_i[0];
        flush    = WBs_DAT_i[1];
        irq_en_d = WBs_DAT_i[2];
      end
      if (sel_rate && WBs_BYTE_STB_i[0]) rate_d[7:0]  = WBs_DAT_i[7:0];
      if (sel_rate && WBs_BYTE_STB_i[1]) rate_d[15:8] = WBs_DAT_i[15:8];
      if (sel_data && (WBs_BYTE_STB_i[1:0] == 2'b11)) push_req = 1'b1;
      if (sel_stat && WBs_BYTE_STB_i[0]) begin
        underrun_clr = WBs_DAT_i[2];
        overflow_clr = WBs_DAT_i[3];
      end
      if (sel_thr && WBs_BYTE_STB_i[0]) thresh_d = WBs_DAT_i[LW-1:0];
    end
  end

  // TX FIFO
  logic [15:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               empty, full, push_ok, pop_ok;
  logic [15:0]        fifo_rdata;

  assign empty      = (level_q == '0);
  assign full       = (level_q == FULL_LVL);
  assign push_ok    = push_req & ~full;
  assign pop_ok     = pop_req & ~empty;
  assign fifo_rdata = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= WBs_DAT_i[15:0];
  end

  assign overflow_d = (push_req & full) | (overflow_q & ~overflow_clr);
  assign underrun_d = underrun_set | (underrun_q & ~underrun_clr);

  // Sample-rate timer: RATE of 0 behaves as 1 (tick every cycle)
  logic [15:0] tmr_q, tmr_d, rate_m1;
  logic        tick;

  assign rate_m1 = (rate_q == '0) ? '0 : rate_q - 16'd1;

  always_comb begin
    tick  = 1'b0;
    tmr_d = tmr_q;
    if (!enable_q) begin
      tmr_d = rate_m1;
    end else if (tmr_q == '0) begin
      tick  = 1'b1;
      tmr_d = rate_m1;
    end else begin
      tmr_d = tmr_q - 16'd1;
    end
  end

  // Serializer
  state_t      state_q, state_d;
  logic [15:0] div_q, div_d, shreg_q, shreg_d;
  logic [3:0]  bit_q, bit_d;
  logic        hi_q, hi_d, pend_q, pend_d, busy;
  logic        sclk_q, sclk_d, sync_n_q, sync_n_d, sdo_q, sdo_d, irq_q, irq_d;
`ifdef DAC_TX_REPEAT_LAST_EN
  logic [15:0] last_q, last_d;
`endif

  assign busy = (state_q != ST_IDLE);

  // One-deep pending tick; dropped whenever the timer is disabled
  always_comb begin
    pend_d = pend_q;
    if (!enable_q)              pend_d = 1'b0;
    else if (state_q == ST_IDLE) pend_d = 1'b0;
    else if (tick)              pend_d = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    hi_d         = hi_q;
    shreg_d      = shreg_q;
    pop_req      = 1'b0;
    underrun_set = 1'b0;
`ifdef DAC_TX_REPEAT_LAST_EN
    last_d       = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enable_q && (tick || pend_q)) begin
          if (!empty) begin
            pop_req = 1'b1;
            shreg_d = fifo_rdata;
            state_d = ST_LOAD;
            div_d   = DIV_M1;
`ifdef DAC_TX_REPEAT_LAST_EN
            last_d  = fifo_rdata;
`endif
          end else begin
            underrun_set = 1'b1;
`ifdef DAC_TX_REPEAT_LAST_EN
            shreg_d = last_q;
            state_d = ST_LOAD;
            div_d   = DIV_M1;
`endif
          end
        end
      end
      ST_LOAD: begin
        if (div_q == '0) begin
          state_d = ST_SHIFT;
          hi_d    = 1'b1;
          bit_d   = '0;
          div_d   = DIV_M1;
        end else begin
          div_d = div_q - 16'd1;
        end
      end
      ST_SHIFT: begin
        if (div_q == '0) begin
          div_d = DIV_M1;
          if (hi_q) begin
            hi_d = 1'b0;
          end else begin
            hi_d    = 1'b1;
            shreg_d = {shreg_q[14:0], 1'b0};
            if (bit_q == 4'd15) begin
              state_d = ST_GAP;
              hi_d    = 1'b0;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end else begin
          div_d = div_q - 16'd1;
        end
      end
      ST_GAP: begin
        if (div_q == '0) state_d = ST_IDLE;
        else             div_d   = div_q - 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin outputs are derived from next-state values so they register cleanly
  always_comb begin
    sync_n_d = ~((state_d == ST_LOAD) || (state_d == ST_SHIFT));
    sclk_d   = (state_d == ST_SHIFT) && hi_d;
    sdo_d    = ~sync_n_d & shreg_d[15];
    irq_d    = irq_en_q & enable_q & (level_q <= thresh_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q      <= 1'b0;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      rate_q     <= 16'd200;
      thresh_q   <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tmr_q      <= '0;
      pend_q     <= 1'b0;
      state_q    <= ST_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      hi_q       <= 1'b0;
      shreg_q    <= '0;
      sclk_q     <= 1'b0;
      sync_n_q   <= 1'b1;
      sdo_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      rate_q     <= rate_d;
      thresh_q   <= thresh_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      tmr_q      <= tmr_d;
      pend_q     <= pend_d;
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      hi_q       <= hi_d;
      shreg_q    <= shreg_d;
      sclk_q     <= sclk_d;
      sync_n_q   <= sync_n_d;
      sdo_q      <= sdo_d;
      irq_q      <= irq_d;
    end
  end

`ifdef DAC_TX_REPEAT_LAST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= '0;
    else     last_q <= last_d;
  end
`endif

  // Register read-back
  always_comb begin
    WBs_DAT_o = DEF_REG_VALUE;
    if (sel_ctrl)      WBs_DAT_o = DATAWIDTH'({irq_en_q, 1'b0, enable_q});
    else if (sel_rate) WBs_DAT_o = DATAWIDTH'(rate_q);
    else if (sel_data) WBs_DAT_o = DATAWIDTH'(level_q);
    else if (sel_stat) WBs_DAT_o = DATAWIDTH'({8'(level_q), 3'b000, busy, overflow_q,
                                               underrun_q, full, empty});
    else if (sel_thr)  WBs_DAT_o = DATAWIDTH'(thresh_q);
  end

  assign WBs_ACK_o    = ack_q;
  assign DAC_SCLK_o   = sclk_q;
  assign DAC_SYNC_n_o = sync_n_q;
  assign DAC_SDO_o    = sdo_q;
  assign TX_Low_IRQ_o = irq_q;

endmodule

// File: tb/tb_dac_tx_streamer.sv
// Directed bench for dac_tx_streamer (default parameters, CLK_DIV = 4).
module tb_dac_tx_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  adr;
  logic        cyc, stb, we;
  logic [3:0]  be;
  logic [31:0] dat_i, dat_o;
  logic        ack, sclk, sync_n, sdo, irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dac_tx_streamer dut (
    .WBs_CLK_i      (clk),
    .WBs_RST_i      (rst),
    .WBs_ADR_i      (adr),
    .WBs_CYC_i      (cyc),
    .WBs_STB_i      (stb),
    .WBs_WE_i       (we),
    .WBs_BYTE_STB_i (be),
    .WBs_DAT_i      (dat_i),
    .WBs_DAT_o      (dat_o),
    .WBs_ACK_o      (ack),
    .DAC_SCLK_o     (sclk),
    .DAC_SYNC_n_o   (sync_n),
    .DAC_SDO_o      (sdo),
    .TX_Low_IRQ_o   (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic w, input logic [9:0] a, input logic [31:0] d, output logic [31:0] r);
    @(negedge clk);
    chk("ack_idle", {31'b0, ack}, 32'd0);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; be = 4'hF;
    @(negedge clk);
    chk("ack_1cyc", {31'b0, ack}, 32'd1);
    r = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    logic [31:0] r;
    wb(1'b1, a, d, r);
  endtask

  task automatic rdchk(input string tag, input logic [9:0] a, input logic [31:0] exp);
    logic [31:0] r;
    wb(1'b0, a, 32'h0, r);
    chk(tag, r, exp);
  endtask

  // Waits for SYNC_n to fall (hi = cycles waited), then records SDO at each SCLK rise.
  task automatic frame(output logic [15:0] bits, output int hi, output int lo, output int rises);
    logic prev;
    hi = 0;
    while (sync_n === 1'b1 && hi < 2000) begin @(negedge clk); hi++; end
    bits = '0; lo = 0; rises = 0; prev = sclk;
    while (sync_n === 1'b0 && lo < 2000) begin
      lo++;
      @(negedge clk);
      if (sclk && !prev) begin bits = {bits[14:0], sdo}; rises++; end
      prev = sclk;
    end
  endtask

  logic [15:0] bits, bits_b;
  int hi, lo, rises, n;
  logic seen;
  logic [15:0] words [3];

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; be = '0; dat_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_sync_n", {31'b0, sync_n}, 32'd1);
    chk("rst_outs", {28'b0, sclk, sdo, irq, ack}, 32'd0);
    rst = 1'b0;

    rdchk("rst_ctrl",   10'h0,  32'h0);
    rdchk("rst_rate",   10'h1,  32'd200);
    rdchk("rst_data",   10'h2,  32'h0);
    rdchk("rst_status", 10'h3,  32'h1);
    rdchk("rst_thresh", 10'h4,  32'h0);
    rdchk("rst_unmap",  10'h7F, 32'hFABDEFAC);

    // Single frame, 200-cycle period
    wr(10'h1, 32'd200);
    wr(10'h2, 32'h0000A5C3);
    wr(10'h0, 32'h1);
    frame(bits, hi, lo, rises);
    chk("f1_latency", hi, 200);
    chk("f1_bits", {16'h0, bits}, 32'h0000A5C3);
    chk("f1_rises", rises, 16);
    chk("f1_sync_low", lo, 132);
    repeat (5) @(negedge clk);
    rdchk("f1_status", 10'h3, 32'h1);
    wr(10'h0, 32'h0);

    // Overflow
    for (int i = 0; i < 17; i++) wr(10'h2, 32'h1000 + i);
    rdchk("ovf_level", 10'h2, 32'd16);
    rdchk("ovf_status", 10'h3, 32'h0000100A);
    wr(10'h3, 32'h8);
    rdchk("ovf_clr", 10'h3, 32'h00001002);
    wr(10'h0, 32'h2);
    rdchk("flush_status", 10'h3, 32'h1);

    // Back-to-back frames, then underrun
    words[0] = 16'h8001; words[1] = 16'h7FFE; words[2] = 16'h00FF;
    wr(10'h1, 32'd50);
    rdchk("rate_rb", 10'h1, 32'd50);
    for (int i = 0; i < 3; i++) wr(10'h2, {16'h0, words[i]});
    wr(10'h0, 32'h1);
    for (int i = 0; i < 3; i++) begin
      frame(bits, hi, lo, rises);
      chk($sformatf("b2b%0d_wait", i), hi, (i == 0) ? 50 : 5);
      chk($sformatf("b2b%0d_bits", i), {16'h0, bits}, {16'h0, words[i]});
    end
`ifdef DAC_TX_REPEAT_LAST_EN
    frame(bits, hi, lo, rises);
    chk("rep_wait", hi, 5);
    chk("rep_bits", {16'h0, bits}, 32'h000000FF);
`else
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (sync_n !== 1'b1) seen = 1'b1; end
    chk("udr_no_frame", {31'b0, seen}, 32'd0);
`endif
    wr(10'h0, 32'h0);
    repeat (10) @(negedge clk);
    rdchk("udr_status", 10'h3, 32'h5);
    wr(10'h3, 32'h4);
    rdchk("udr_clr", 10'h3, 32'h1);

    // Low-watermark IRQ
    wr(10'h4, 32'd2);
    rdchk("thr_rb", 10'h4, 32'd2);
    wr(10'h1, 32'd10);
    for (int i = 0; i < 4; i++) wr(10'h2, 32'h0F00 + i);
    wr(10'h0, 32'h5);
    rdchk("ctrl_rb", 10'h0, 32'h5);
    frame(bits, hi, lo, rises);
    chk("irq_f1_bits", {16'h0, bits}, 32'h00000F00);
    n = 0;
    while (sync_n === 1'b1 && n < 500) begin @(negedge clk); n++; end
    chk("irq_pre", {31'b0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_assert", {31'b0, irq}, 32'd1);
    wr(10'h2, 32'h0F10);
    chk("irq_hold", {31'b0, irq}, 32'd1);
    @(negedge clk);
    chk("irq_deassert", {31'b0, irq}, 32'd0);
    wr(10'h0, 32'h0);
    wr(10'h0, 32'h2);
    repeat (150) @(negedge clk);

    // FLUSH while a frame is shifting
    wr(10'h3, 32'hC);
    wr(10'h1, 32'd300);
    wr(10'h2, 32'h3C5A);
    for (int i = 1; i < 5; i++) wr(10'h2, 32'h5500 + i);
    wr(10'h0, 32'h1);
    fork
      frame(bits_b, hi, lo, rises);
      begin
        n = 0;
        while (sync_n === 1'b1 && n < 1000) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        wr(10'h0, 32'h3);
        rdchk("flush_level", 10'h2, 32'h0);
      end
    join
    chk("flush_bits", {16'h0, bits_b}, 32'h00003C5A);
    chk("flush_wait", hi, 300);
    chk("flush_sync_low", lo, 132);
    repeat (200) @(negedge clk);
`ifdef DAC_TX_REPEAT_LAST_EN
    rdchk("flush_udr", 10'h3, 32'h15);
`else
    rdchk("flush_udr", 10'h3, 32'h5);
`endif

    // Reset mid-frame
    wr(10'h2, 32'hFFFF);
    n = 0;
    while (sync_n === 1'b1 && n < 1000) begin @(negedge clk); n++; end
    chk("rst_mid_framing", {31'b0, sync_n}, 32'd0);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_sync", {31'b0, sync_n}, 32'd1);
    chk("rst_mid_outs", {29'b0, sclk, sdo, irq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rdchk("rst_mid_status", 10'h3, 32'h1);
    rdchk("rst_mid_rate", 10'h1, 32'd200);
    rdchk("rst_mid_ctrl", 10'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
